// File: rtl/vend_dispenser.sv
// Vend/change dispenser: drives the product motor, then ejects nickels via hopper handshake.
// Optional VEND_DISPENSER_COUNT_EN adds a saturating coins_out counter.
module vend_dispenser #(
  parameter int VEND_CYCLES    = 8,
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soda,
  input  logic [2:0] change,
  input  logic       hopper_coin,
  output logic       vend_motor,
  output logic       eject_nickel,
  output logic       busy,
  output logic       done,
  output logic       fault
`ifdef VEND_DISPENSER_COUNT_EN
  ,
  output logic [15:0] coins_out
`endif
);

  localparam int MAX_A =
    (VEND_CYCLES > PULSE_CYCLES) ? VEND_CYCLES : PULSE_CYCLES;
  localparam int MAX_B =
    (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] V_LAST = CW'(VEND_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, VEND, EJECT, WAIT_ACK, GAP, DONE, FAULT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    rem, rem_n;
  logic          ack_seen, ack_seen_n;
  logic          soda_q, coin_q;
  logic          start, coin_rise, ack;
  logic [2:0]    chg_clamp;

  assign start     = soda & ~soda_q;
  assign coin_rise = hopper_coin & ~coin_q;
  assign chg_clamp = (change > 3'd4) ? 3'd4 : change;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      ack_seen <= 1'b0;
      soda_q   <= 1'b0;
      coin_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      ack_seen <= ack_seen_n;
      soda_q   <= soda;
      coin_q   <= hopper_coin;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    ack_seen_n = ack_seen;
    ack        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n    = VEND;
          cnt_n      = '0;
          rem_n      = chg_clamp;
          ack_seen_n = 1'b0;
        end
      end
      VEND: begin
        if (cnt == V_LAST) begin
          cnt_n   = '0;
          state_n = (rem == 3'd0) ? DONE : EJECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EJECT: begin
        if (coin_rise) ack_seen_n = 1'b1;
        if (cnt == P_LAST) begin
          cnt_n = '0;
          if (ack_seen || coin_rise) ack = 1'b1;
          else state_n = WAIT_ACK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (coin_rise) ack = 1'b1;
        else if (cnt == T_LAST) state_n = FAULT;
        else cnt_n = cnt + 1'b1;
      end
      GAP: begin
        if (cnt == G_LAST) begin
          cnt_n   = '0;
          state_n = EJECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
    // A coin acknowledge overrides the per-state transition above
    if (ack) begin
      rem_n      = (rem == 3'd0) ? 3'd0 : rem - 3'd1;
      ack_seen_n = 1'b0;
      cnt_n      = '0;
      state_n    = (rem <= 3'd1) ? DONE : GAP;
    end
  end

  assign vend_motor   = (state == VEND);
  assign eject_nickel = (state == EJECT);
  assign busy         = state inside {VEND, EJECT, WAIT_ACK, GAP};
  assign done         = (state == DONE);
  assign fault        = (state == FAULT);

`ifdef VEND_DISPENSER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) coins_out <= '0;
    else if (ack && coins_out != 16'hFFFF) coins_out <= coins_out + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed testbench for vend_dispenser.
// Define VEND_DISPENSER_COUNT_EN to also check coins_out.
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soda = 1'b0;
  logic [2:0] change = 3'd0;
  logic       hopper_coin = 1'b0;
  logic       vend_motor, eject_nickel, busy, done, fault;
`ifdef VEND_DISPENSER_COUNT_EN
  logic [15:0] coins_out;
`endif

  int passed = 0;
  int total = 0;
  int exp_coins = 0;

  vend_dispenser dut (
    .clk(clk),
    .rst(rst),
    .soda(soda),
    .change(change),
    .hopper_coin(hopper_coin),
    .vend_motor(vend_motor),
    .eject_nickel(eject_nickel),
    .busy(busy),
    .done(done),
    .fault(fault)
`ifdef VEND_DISPENSER_COUNT_EN
    ,
    .coins_out(coins_out)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: pulse lengths and activity counts
  int vend_hi, done_cnt, ej_run, low_run;
  bit ej_prev, seen_ej;
  int ej_lens[$];
  int low_lens[$];

  always @(posedge clk) begin
    #2;
    if (vend_motor) vend_hi++;
    if (done) done_cnt++;
    if (eject_nickel) begin
      if (!ej_prev && seen_ej) low_lens.push_back(low_run);
      ej_run++;
    end else begin
      if (ej_prev) begin
        ej_lens.push_back(ej_run);
        ej_run  = 0;
        low_run = 0;
        seen_ej = 1;
      end
      low_run++;
    end
    ej_prev = eject_nickel;
  end

  task automatic mon_clr();
    vend_hi = 0; done_cnt = 0; ej_run = 0; low_run = 0;
    ej_prev = 0; seen_ej = 0;
    ej_lens.delete();
    low_lens.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({vend_motor, eject_nickel, busy, done, fault} !== 5'b0) begin
      $display("FAIL reset_outs: got %b want 00000",
               {vend_motor, eject_nickel, busy, done, fault});
    end else passed++;
    tick();
    total++;
    if ({vend_motor, eject_nickel, busy, done, fault} !== 5'b0) begin
      $display("FAIL reset_idle: got %b want 00000",
               {vend_motor, eject_nickel, busy, done, fault});
    end else passed++;
`ifdef VEND_DISPENSER_COUNT_EN
    exp_coins = 0;
    total++;
    if (coins_out !== 16'(exp_coins)) begin
      $display("FAIL reset_coins: got %0d want %0d", coins_out, exp_coins);
    end else passed++;
`endif
  endtask

  task automatic test_no_change();
    bit got = 0;
    mon_clr();
    soda = 1'b1;
    change = 3'd0;
    tick();
    soda = 1'b0;
    total++;
    if ({vend_motor, busy} !== 2'b11) begin
      $display("FAIL nc_start: got %b want 11", {vend_motor, busy});
    end else passed++;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (done) got = 1;
    end
    total++;
    if (!got || busy !== 1'b0) begin
      $display("FAIL nc_done: got done=%0d busy=%b want 1 0", got, busy);
    end else passed++;
    total++;
    if (vend_hi != 8) begin
      $display("FAIL nc_vend_len: got %0d want 8", vend_hi);
    end else passed++;
    tick();
    total++;
    if (done !== 1'b0 || done_cnt != 1 || ej_lens.size() != 0) begin
      $display("FAIL nc_after: got done=%b cnt=%0d ej=%0d want 0 1 0",
               done, done_cnt, ej_lens.size());
    end else passed++;
  endtask

  task automatic test_change3();
    bit got = 0;
    bit prev = 0;
    int fall = -100;
    int cyc = 0;
    mon_clr();
    soda = 1'b1;
    change = 3'd3;
    tick();
    soda = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      cyc++;
      hopper_coin = 1'b0;
      if (prev && !eject_nickel) fall = cyc;
      if (cyc == fall + 2) hopper_coin = 1'b1;
      prev = eject_nickel;
      if (done) got = 1;
    end
    hopper_coin = 1'b0;
    total++;
    if (!got || busy !== 1'b0 || fault !== 1'b0) begin
      $display("FAIL c3_done: got done=%0d busy=%b fault=%b want 1 0 0",
               got, busy, fault);
    end else passed++;
    tick();
    exp_coins += 3;
    total++;
    if (ej_lens.size() != 3) begin
      $display("FAIL c3_ejects: got %0d want 3", ej_lens.size());
    end else passed++;
    foreach (ej_lens[k]) begin
      total++;
      if (ej_lens[k] != 4) begin
        $display("FAIL c3_pulse%0d: got %0d want 4", k, ej_lens[k]);
      end else passed++;
    end
    total++;
    if (low_lens.size() != 2) begin
      $display("FAIL c3_gaps: got %0d want 2", low_lens.size());
    end else passed++;
    foreach (low_lens[k]) begin
      total++;
      if (low_lens[k] != 5) begin
        $display("FAIL c3_gap%0d: got %0d want 5 (3 wait + 2 gap)",
                 k, low_lens[k]);
      end else passed++;
    end
    total++;
    if (done_cnt != 1) begin
      $display("FAIL c3_done_cnt: got %0d want 1", done_cnt);
    end else passed++;
  endtask

  task automatic test_clamp();
    bit got = 0;
    bit prev = 0;
    mon_clr();
    soda = 1'b1;
    change = 3'd7;
    tick();
    soda = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      hopper_coin = eject_nickel && !prev;
      prev = eject_nickel;
      if (done) got = 1;
    end
    hopper_coin = 1'b0;
    total++;
    if (!got) begin
      $display("FAIL cl_done: got 0 want 1");
    end else passed++;
    tick();
    exp_coins += 4;
    total++;
    if (ej_lens.size() != 4) begin
      $display("FAIL cl_ejects: got %0d want 4", ej_lens.size());
    end else passed++;
    foreach (low_lens[k]) begin
      total++;
      if (low_lens[k] != 2) begin
        $display("FAIL cl_gap%0d: got %0d want 2", k, low_lens[k]);
      end else passed++;
    end
    total++;
    if (fault !== 1'b0 || done_cnt != 1) begin
      $display("FAIL cl_end: got fault=%b done_cnt=%0d want 0 1",
               fault, done_cnt);
    end else passed++;
`ifdef VEND_DISPENSER_COUNT_EN
    total++;
    if (coins_out !== 16'(exp_coins)) begin
      $display("FAIL cl_coins: got %0d want %0d", coins_out, exp_coins);
    end else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    mon_clr();
    soda = 1'b1;
    change = 3'd0;
    tick();
    soda = 1'b0;
    tick();
    tick();
    soda = 1'b1;
    tick();
    soda = 1'b0;
    repeat (25) tick();
    total++;
    if (vend_hi != 8 || done_cnt != 1 || busy !== 1'b0) begin
      $display("FAIL b2b: got vend=%0d done=%0d busy=%b want 8 1 0",
               vend_hi, done_cnt, busy);
    end else passed++;
  endtask

  task automatic test_timeout();
    bit got = 0;
    bit prev = 0;
    int fall = -1;
    int cyc = 0;
    mon_clr();
    hopper_coin = 1'b0;
    soda = 1'b1;
    change = 3'd2;
    tick();
    soda = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      cyc++;
      if (prev && !eject_nickel && fall < 0) fall = cyc;
      prev = eject_nickel;
      if (fault) got = 1;
    end
    total++;
    if (!got || (cyc - fall) != 255) begin
      $display("FAIL to_delay: got fault=%0d delay=%0d want 1 255",
               got, cyc - fall);
    end else passed++;
    total++;
    if ({vend_motor, eject_nickel, busy, done} !== 4'b0) begin
      $display("FAIL to_outs: got %b want 0000",
               {vend_motor, eject_nickel, busy, done});
    end else passed++;
    total++;
    if (ej_lens.size() != 1 || ej_lens[0] != 4) begin
      $display("FAIL to_eject: got n=%0d want 1 pulse of 4", ej_lens.size());
    end else passed++;
    soda = 1'b1;
    tick();
    soda = 1'b0;
    repeat (4) tick();
    total++;
    if ({vend_motor, busy, fault} !== 3'b001 || done_cnt != 0) begin
      $display("FAIL to_sticky: got %b done=%0d want 001 0",
               {vend_motor, busy, fault}, done_cnt);
    end else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_coins = 0;
    total++;
    if (fault !== 1'b0) begin
      $display("FAIL to_clear: got %b want 0", fault);
    end else passed++;
  endtask

  task automatic test_rst_mid();
    bit got = 0;
    bit prev = 0;
    int rises = 0;
    int fall = -100;
    int cyc = 0;
    mon_clr();
    soda = 1'b1;
    change = 3'd3;
    tick();
    soda = 1'b0;
    for (int i = 0; i < 300 && rises < 2; i++) begin
      tick();
      cyc++;
      hopper_coin = 1'b0;
      if (prev && !eject_nickel) fall = cyc;
      if (!prev && eject_nickel) rises++;
      if (cyc == fall + 2) hopper_coin = 1'b1;
      prev = eject_nickel;
    end
    hopper_coin = 1'b0;
    tick();
    total++;
    if (eject_nickel !== 1'b1) begin
      $display("FAIL rm_in_eject: got %b want 1", eject_nickel);
    end else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_coins = 0;
    total++;
    if ({vend_motor, eject_nickel, busy, done, fault} !== 5'b0) begin
      $display("FAIL rm_abort: got %b want 00000",
               {vend_motor, eject_nickel, busy, done, fault});
    end else passed++;
    repeat (3) tick();
    total++;
    if ({vend_motor, eject_nickel, busy, done, fault} !== 5'b0) begin
      $display("FAIL rm_idle: got %b want 00000",
               {vend_motor, eject_nickel, busy, done, fault});
    end else passed++;
    mon_clr();
    prev = 0;
    soda = 1'b1;
    change = 3'd1;
    tick();
    soda = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      hopper_coin = eject_nickel && !prev;
      prev = eject_nickel;
      if (done) got = 1;
    end
    hopper_coin = 1'b0;
    tick();
    exp_coins += 1;
    total++;
    if (!got || done_cnt != 1 || ej_lens.size() != 1 || vend_hi != 8) begin
      $display("FAIL rm_resale: got done=%0d/%0d ej=%0d vend=%0d want 1/1 1 8",
               got, done_cnt, ej_lens.size(), vend_hi);
    end else passed++;
`ifdef VEND_DISPENSER_COUNT_EN
    total++;
    if (coins_out !== 16'(exp_coins)) begin
      $display("FAIL rm_coins: got %0d want %0d", coins_out, exp_coins);
    end else passed++;
`endif
  endtask

  initial begin
    mon_clr();
    test_reset();
    test_no_change();
    test_change3();
    test_clamp();
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
